excp_arbiter: RTL and testbench
===============================

EXCP_ARBITER -- requirements
Module: excp_arbiter

Interface
REQ-001 Parameter PIPE_NUM, default 2: number of commit pipes; pipe 0 is oldest.
REQ-002 Parameter DRAIN_CYCLES, default 2: post-redirect quiet cycles, range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 valid_i  input  PIPE_NUM  instruction present in pipe p.
REQ-006 excp_i  input  PIPE_NUM x excp_flow_t  upstream flags (adef, itlbr, pif, ippi, ipe, ale, adem, dtlbr).
REQ-007 syscall_i, brk_i, ine_i  input  PIPE_NUM each  decoder exception hints.
REQ-008 mem_valid_i, mem_write_i  input  PIPE_NUM each  memory access type.
REQ-009 vpc_i, vlsu_i  input  PIPE_NUM x 32  instruction PC and data virtual address.
REQ-010 trans_en_i  input  1  mapped translation enabled.
REQ-011 plv_i  input  2  current privilege level.
REQ-012 mmu_resp_i  input  PIPE_NUM x mmu_resp_t  data-side TLB response (v, d, plv).
REQ-013 int_pending_i  input  1  qualified interrupt (CRMD.IE already applied).
REQ-014 redirect_ready_i  input  1  fetch accepts redirect.
REQ-015 kill_o  output  PIPE_NUM  combinational; squash pipe p this cycle.
REQ-016 excp_valid_o  output  1  registered one-cycle commit pulse to CSR.
REQ-017 ecode_o / esubcode_o  output  6 / 9  registered cause codes.
REQ-018 era_o, bad_va_o  output  32 each  registered ERA and BADV.
REQ-019 va_error_o, tlbrefill_o  output  1 each  registered BADV-write and TLBR-entry flags.
REQ-020 redirect_valid_o  output  1  redirect request to fetch.
REQ-021 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-022 Per-pipe cause priority, highest first: INT (pipe 0 only), ADEF, ITLBR, PIF, IPPI, SYS/BRK, INE, IPE, ALE, ADEM, DTLBR, PME, DPPI, PIS/PIL.
REQ-023 PME: trans_en_i & v & !d & mem_write_i; DPPI: trans_en_i & v & mem_valid_i & plv_i > resp.plv; PIS/PIL: trans_en_i & mem_valid_i & !v, PIS when mem_write_i.
REQ-024 bad_va: vpc_i for fetch-side causes, vlsu_i for ALE/ADEM/DTLBR/PME/DPPI/PIS/PIL; va_error set for exactly those causes; tlbrefill set for ITLBR and DTLBR only.
REQ-025 INT: ecode 0, va_error 0; applies only when valid_i[0] is high.
REQ-026 Winner = lowest-index valid pipe with any cause; kill_o asserted for the winner and all higher-index pipes, same cycle.
REQ-027 FSM states IDLE, REDIRECT, DRAIN.
REQ-028 IDLE with winner: register outputs, pulse excp_valid_o next cycle, go REDIRECT; era_o = winner vpc_i.
REQ-029 REDIRECT: redirect_valid_o held high until redirect_ready_i; on handshake go DRAIN, load counter with DRAIN_CYCLES-1.
REQ-030 DRAIN: decrement counter each cycle; exit to IDLE when count is 0.
REQ-031 In REDIRECT and DRAIN, kill_o all ones and new exceptions ignored.
REQ-032 ecode/esubcode/era/bad_va/va_error/tlbrefill hold until next capture.
REQ-033 esubcode 0 for all causes; counter width 4 bits.

Reset
REQ-034 rst: state IDLE, counter 0, every registered output 0, redirect_valid_o 0; rst dominates any concurrent exception or handshake.

Structure
REQ-035 ecode constants, excp_flow_t, mmu_resp_t and the fsm state enum SHALL live in the shared package.
REQ-036 One sub-module excp_cause_enc (combinational per-pipe encoder), instantiated PIPE_NUM times.

Verification
REQ-037 Pipe1 ale, vlsu=0x1003, pipe0 clean -> next cycle ecode ALE, bad_va 0x1003, era=vpc1, kill_o=2'b10.
REQ-038 Pipe0 syscall bit16=1 and pipe1 adef -> ecode SYS, kill_o=2'b11, pipe1 ignored.
REQ-039 Pipe0 int_pending and itlbr -> ecode 0, tlbrefill 0.
REQ-040 redirect_ready_i low 5 cycles -> redirect_valid_o held 5 cycles; DRAIN lasts 2 cycles then busy_o 0.
REQ-041 rst asserted during REDIRECT -> next cycle IDLE, all outputs 0.
REQ-042 PIPE_NUM=4, pipe2 pme, pipe3 pis -> PME, kill_o=4'b1100.

Source files
------------

// File: rtl/excp_arbiter_pkg.sv
// Shared types and cause codes for the commit-stage exception arbiter.
package excp_arbiter_pkg;

    typedef struct packed {
        logic adef;
        logic itlbr;
        logic pif;
        logic ippi;
        logic ipe;
        logic ale;
        logic adem;
        logic dtlbr;
    } excp_flow_t;

    typedef struct packed {
        logic       v;
        logic       d;
        logic [1:0] plv;
    } mmu_resp_t;

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StDrain
    } state_e;

    localparam int unsigned CntW = 4;

    localparam logic [5:0] EcodeInt  = 6'h00;
    localparam logic [5:0] EcodePil  = 6'h01;
    localparam logic [5:0] EcodePis  = 6'h02;
    localparam logic [5:0] EcodePif  = 6'h03;
    localparam logic [5:0] EcodePme  = 6'h04;
    localparam logic [5:0] EcodePpi  = 6'h07;
    localparam logic [5:0] EcodeAde  = 6'h08;
    localparam logic [5:0] EcodeAle  = 6'h09;
    localparam logic [5:0] EcodeSys  = 6'h0b;
    localparam logic [5:0] EcodeBrk  = 6'h0c;
    localparam logic [5:0] EcodeIne  = 6'h0d;
    localparam logic [5:0] EcodeIpe  = 6'h0e;
    localparam logic [5:0] EcodeTlbr = 6'h3f;

endpackage

// File: rtl/excp_cause_enc.sv
// Combinational per-pipe cause encoder: picks the highest-priority cause of one pipe.
module excp_cause_enc
    import excp_arbiter_pkg::*;
(
    input  logic        valid_i,
    input  logic        int_i,
    input  excp_flow_t  excp_i,
    input  logic        syscall_i,
    input  logic        brk_i,
    input  logic        ine_i,
    input  logic        mem_valid_i,
    input  logic        mem_write_i,
    input  logic [31:0] vpc_i,
    input  logic [31:0] vlsu_i,
    input  logic        trans_en_i,
    input  logic [1:0]  plv_i,
    input  mmu_resp_t   mmu_resp_i,
    output logic        hit_o,
    output logic [5:0]  ecode_o,
    output logic        va_error_o,
    output logic        tlbrefill_o,
    output logic [31:0] bad_va_o
);

    logic pme, dppi, pil_pis;

    assign pme     = trans_en_i & mmu_resp_i.v & ~mmu_resp_i.d & mem_write_i;
    assign dppi    = trans_en_i & mmu_resp_i.v & mem_valid_i & (plv_i > mmu_resp_i.plv);
    assign pil_pis = trans_en_i & mem_valid_i & ~mmu_resp_i.v;

    always_comb begin
        hit_o       = 1'b1;
        ecode_o     = EcodeInt;
        va_error_o  = 1'b0;
        tlbrefill_o = 1'b0;
        bad_va_o    = vpc_i;
        if (int_i) begin
            ecode_o = EcodeInt;
        end else if (excp_i.adef) begin
            ecode_o    = EcodeAde;
            va_error_o = 1'b1;
        end else if (excp_i.itlbr) begin
            ecode_o     = EcodeTlbr;
            va_error_o  = 1'b1;
            tlbrefill_o = 1'b1;
        end else if (excp_i.pif) begin
            ecode_o    = EcodePif;
            va_error_o = 1'b1;
        end else if (excp_i.ippi) begin
            ecode_o    = EcodePpi;
            va_error_o = 1'b1;
        end else if (syscall_i) begin
            ecode_o = EcodeSys;
        end else if (brk_i) begin
            ecode_o = EcodeBrk;
        end else if (ine_i) begin
            ecode_o = EcodeIne;
        end else if (excp_i.ipe) begin
            ecode_o = EcodeIpe;
        end else if (excp_i.ale) begin
            ecode_o    = EcodeAle;
            va_error_o = 1'b1;
            bad_va_o   = vlsu_i;
        end else if (excp_i.adem) begin
            ecode_o    = EcodeAde;
            va_error_o = 1'b1;
            bad_va_o   = vlsu_i;
        end else if (excp_i.dtlbr) begin
            ecode_o     = EcodeTlbr;
            va_error_o  = 1'b1;
            tlbrefill_o = 1'b1;
            bad_va_o    = vlsu_i;
        end else if (pme) begin
            ecode_o    = EcodePme;
            va_error_o = 1'b1;
            bad_va_o   = vlsu_i;
        end else if (dppi) begin
            ecode_o    = EcodePpi;
            va_error_o = 1'b1;
            bad_va_o   = vlsu_i;
        end else if (pil_pis) begin
            ecode_o    = mem_write_i ? EcodePis : EcodePil;
            va_error_o = 1'b1;
            bad_va_o   = vlsu_i;
        end else begin
            hit_o = 1'b0;
        end
        if (!valid_i) begin
            hit_o = 1'b0;
        end
    end

endmodule

// File: rtl/excp_arbiter.sv
// Commit-stage exception arbiter: selects the oldest faulting pipe, reports it to CSR
// and sequences the fetch redirect plus a short drain window.
module excp_arbiter
    import excp_arbiter_pkg::*;
#(
    parameter int unsigned PIPE_NUM     = 2,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PIPE_NUM-1:0]       valid_i,
    input  excp_flow_t [PIPE_NUM-1:0] excp_i,
    input  logic [PIPE_NUM-1:0]       syscall_i,
    input  logic [PIPE_NUM-1:0]       brk_i,
    input  logic [PIPE_NUM-1:0]       ine_i,
    input  logic [PIPE_NUM-1:0]       mem_valid_i,
    input  logic [PIPE_NUM-1:0]       mem_write_i,
    input  logic [PIPE_NUM-1:0][31:0] vpc_i,
    input  logic [PIPE_NUM-1:0][31:0] vlsu_i,
    input  logic                      trans_en_i,
    input  logic [1:0]                plv_i,
    input  mmu_resp_t [PIPE_NUM-1:0]  mmu_resp_i,
    input  logic                      int_pending_i,
    input  logic                      redirect_ready_i,
    output logic [PIPE_NUM-1:0]       kill_o,
    output logic                      excp_valid_o,
    output logic [5:0]                ecode_o,
    output logic [8:0]                esubcode_o,
    output logic [31:0]               era_o,
    output logic [31:0]               bad_va_o,
    output logic                      va_error_o,
    output logic                      tlbrefill_o,
    output logic                      redirect_valid_o,
    output logic                      busy_o
);

    logic [PIPE_NUM-1:0]       hit, va_err_p, tlbr_p, kill_raw;
    logic [PIPE_NUM-1:0][5:0]  ecode_p;
    logic [PIPE_NUM-1:0][31:0] bad_va_p;

    for (genvar p = 0; p < PIPE_NUM; p++) begin : g_enc
        excp_cause_enc u_enc (
            .valid_i     (valid_i[p]),
            .int_i       ((p == 0) && int_pending_i),
            .excp_i      (excp_i[p]),
            .syscall_i   (syscall_i[p]),
            .brk_i       (brk_i[p]),
            .ine_i       (ine_i[p]),
            .mem_valid_i (mem_valid_i[p]),
            .mem_write_i (mem_write_i[p]),
            .vpc_i       (vpc_i[p]),
            .vlsu_i      (vlsu_i[p]),
            .trans_en_i  (trans_en_i),
            .plv_i       (plv_i),
            .mmu_resp_i  (mmu_resp_i[p]),
            .hit_o       (hit[p]),
            .ecode_o     (ecode_p[p]),
            .va_error_o  (va_err_p[p]),
            .tlbrefill_o (tlbr_p[p]),
            .bad_va_o    (bad_va_p[p])
        );
    end

    logic        win_found;
    logic [5:0]  sel_ecode;
    logic [31:0] sel_era, sel_bad_va;
    logic        sel_va_error, sel_tlbrefill;

    // Ascending scan: the first hit is the oldest faulting pipe; everything from it up is killed.
    always_comb begin
        win_found     = 1'b0;
        sel_ecode     = '0;
        sel_era       = '0;
        sel_bad_va    = '0;
        sel_va_error  = 1'b0;
        sel_tlbrefill = 1'b0;
        kill_raw      = '0;
        for (int p = 0; p < PIPE_NUM; p++) begin
            if (hit[p] && !win_found) begin
                sel_ecode     = ecode_p[p];
                sel_era       = vpc_i[p];
                sel_bad_va    = bad_va_p[p];
                sel_va_error  = va_err_p[p];
                sel_tlbrefill = tlbr_p[p];
            end
            win_found   = win_found | hit[p];
            kill_raw[p] = win_found;
        end
    end

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    capture = 1'b1;
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                if (redirect_ready_i) begin
                    state_d = StDrain;
                    cnt_d   = CntW'(DRAIN_CYCLES - 1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic        excp_valid_q, va_error_q, tlbrefill_q;
    logic [5:0]  ecode_q;
    logic [31:0] era_q, bad_va_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            excp_valid_q <= 1'b0;
            ecode_q      <= '0;
            era_q        <= '0;
            bad_va_q     <= '0;
            va_error_q   <= 1'b0;
            tlbrefill_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            excp_valid_q <= capture;
            if (capture) begin
                ecode_q     <= sel_ecode;
                era_q       <= sel_era;
                bad_va_q    <= sel_bad_va;
                va_error_q  <= sel_va_error;
                tlbrefill_q <= sel_tlbrefill;
            end
        end
    end

    assign kill_o           = (state_q == StIdle) ? kill_raw : '1;
    assign excp_valid_o     = excp_valid_q;
    assign ecode_o          = ecode_q;
    assign esubcode_o       = '0;
    assign era_o            = era_q;
    assign bad_va_o         = bad_va_q;
    assign va_error_o       = va_error_q;
    assign tlbrefill_o      = tlbrefill_q;
    assign redirect_valid_o = (state_q == StRedirect);
    assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_excp_arbiter.sv
// Self-checking bench for excp_arbiter: cause-list reference model plus directed cases.
module tb_excp_arbiter;
    import excp_arbiter_pkg::*;

    localparam int DRAIN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       valid, syscall, brk, ine, mem_valid, mem_write;
    excp_flow_t [1:0] excp;
    logic [1:0][31:0] vpc, vlsu;
    mmu_resp_t [1:0]  mmu_resp;
    logic             trans_en, int_pending, redirect_ready;
    logic [1:0]       plv;
    logic [1:0]       kill_o;
    logic             excp_valid_o, va_error_o, tlbrefill_o, redirect_valid_o, busy_o;
    logic [5:0]       ecode_o;
    logic [8:0]       esubcode_o;
    logic [31:0]      era_o, bad_va_o;

    logic [3:0]       valid4, syscall4, brk4, ine4, mem_valid4, mem_write4, kill4;
    excp_flow_t [3:0] excp4;
    logic [3:0][31:0] vpc4, vlsu4;
    mmu_resp_t [3:0]  mmu_resp4;
    logic             excp_valid4, va_error4, tlbrefill4, redirect_valid4, busy4;
    logic [5:0]       ecode4;
    logic [8:0]       esubcode4;
    logic [31:0]      era4, bad_va4;

    excp_arbiter #(.PIPE_NUM(2), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .valid_i(valid), .excp_i(excp), .syscall_i(syscall),
        .brk_i(brk), .ine_i(ine), .mem_valid_i(mem_valid), .mem_write_i(mem_write),
        .vpc_i(vpc), .vlsu_i(vlsu), .trans_en_i(trans_en), .plv_i(plv),
        .mmu_resp_i(mmu_resp), .int_pending_i(int_pending),
        .redirect_ready_i(redirect_ready), .kill_o(kill_o), .excp_valid_o(excp_valid_o),
        .ecode_o(ecode_o), .esubcode_o(esubcode_o), .era_o(era_o), .bad_va_o(bad_va_o),
        .va_error_o(va_error_o), .tlbrefill_o(tlbrefill_o),
        .redirect_valid_o(redirect_valid_o), .busy_o(busy_o)
    );

    excp_arbiter #(.PIPE_NUM(4), .DRAIN_CYCLES(DRAIN)) dut4 (
        .clk(clk), .rst(rst), .valid_i(valid4), .excp_i(excp4), .syscall_i(syscall4),
        .brk_i(brk4), .ine_i(ine4), .mem_valid_i(mem_valid4), .mem_write_i(mem_write4),
        .vpc_i(vpc4), .vlsu_i(vlsu4), .trans_en_i(trans_en), .plv_i(plv),
        .mmu_resp_i(mmu_resp4), .int_pending_i(int_pending),
        .redirect_ready_i(redirect_ready), .kill_o(kill4), .excp_valid_o(excp_valid4),
        .ecode_o(ecode4), .esubcode_o(esubcode4), .era_o(era4), .bad_va_o(bad_va4),
        .va_error_o(va_error4), .tlbrefill_o(tlbrefill4),
        .redirect_valid_o(redirect_valid4), .busy_o(busy4)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cause index in priority order; 0 means no exception for this pipe.
    function automatic int cause_of(int p);
        if (!valid[p]) return 0;
        if (p == 0 && int_pending) return 1;
        if (excp[p].adef) return 2;
        if (excp[p].itlbr) return 3;
        if (excp[p].pif) return 4;
        if (excp[p].ippi) return 5;
        if (syscall[p]) return 6;
        if (brk[p]) return 7;
        if (ine[p]) return 8;
        if (excp[p].ipe) return 9;
        if (excp[p].ale) return 10;
        if (excp[p].adem) return 11;
        if (excp[p].dtlbr) return 12;
        if (trans_en && mmu_resp[p].v && !mmu_resp[p].d && mem_write[p]) return 13;
        if (trans_en && mmu_resp[p].v && mem_valid[p] && plv > mmu_resp[p].plv) return 14;
        if (trans_en && mem_valid[p] && !mmu_resp[p].v) return mem_write[p] ? 15 : 16;
        return 0;
    endfunction

    function automatic logic [5:0] ecode_of(int c);
        case (c)
            2, 11:   return 6'h08;
            3, 12:   return 6'h3f;
            4:       return 6'h03;
            5, 14:   return 6'h07;
            6:       return 6'h0b;
            7:       return 6'h0c;
            8:       return 6'h0d;
            9:       return 6'h0e;
            10:      return 6'h09;
            13:      return 6'h04;
            15:      return 6'h02;
            16:      return 6'h01;
            default: return 6'h00;
        endcase
    endfunction

    function automatic int winner();
        for (int p = 0; p < 2; p++) if (cause_of(p) != 0) return p;
        return -1;
    endfunction

    function automatic logic [31:0] badva_of(int p);
        return (cause_of(p) >= 10) ? vlsu[p] : vpc[p];
    endfunction

    // Model state: waiting for the redirect handshake, then a count of quiet cycles left.
    bit          m_wait = 1'b0;
    int          m_drain = 0;
    logic        m_ev = 1'b0, m_vaerr = 1'b0, m_tlbr = 1'b0;
    logic [5:0]  m_ecode = '0;
    logic [31:0] m_era = '0, m_badva = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_wait <= 1'b0; m_drain <= 0; m_ev <= 1'b0; m_ecode <= '0;
            m_era <= '0; m_badva <= '0; m_vaerr <= 1'b0; m_tlbr <= 1'b0;
        end else begin
            m_ev <= 1'b0;
            if (m_drain > 0) begin
                m_drain <= m_drain - 1;
            end else if (m_wait) begin
                if (redirect_ready) begin
                    m_wait  <= 1'b0;
                    m_drain <= DRAIN;
                end
            end else if (winner() >= 0) begin
                m_ev    <= 1'b1;
                m_wait  <= 1'b1;
                m_ecode <= ecode_of(cause_of(winner()));
                m_era   <= vpc[winner()];
                m_badva <= badva_of(winner());
                m_vaerr <= (cause_of(winner()) inside {[2:5], [10:16]});
                m_tlbr  <= (cause_of(winner()) inside {3, 12});
            end
        end
    end

    function automatic logic [1:0] exp_kill();
        int w;
        if (m_wait || m_drain > 0) return 2'b11;
        w = winner();
        if (w == 0) return 2'b11;
        if (w == 1) return 2'b10;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_kill", 32'(kill_o), 32'(exp_kill()));
            chk("m_excp_valid", 32'(excp_valid_o), 32'(m_ev));
            chk("m_redirect_valid", 32'(redirect_valid_o), 32'(m_wait));
            chk("m_busy", 32'(busy_o), 32'(m_wait || m_drain > 0));
            chk("m_ecode", 32'(ecode_o), 32'(m_ecode));
            chk("m_esubcode", 32'(esubcode_o), 32'd0);
            chk("m_era", 32'(era_o), m_era);
            chk("m_va_error", 32'(va_error_o), 32'(m_vaerr));
            chk("m_tlbrefill", 32'(tlbrefill_o), 32'(m_tlbr));
            if (m_vaerr) chk("m_bad_va", bad_va_o, m_badva);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        valid = '0; syscall = '0; brk = '0; ine = '0; mem_valid = '0; mem_write = '0;
        excp = '0; mmu_resp = '0; vpc[0] = 32'h0000_0100; vpc[1] = 32'h0000_0104;
        vlsu = '0; trans_en = 1'b0; int_pending = 1'b0; plv = 2'd0;
        valid4 = '0; syscall4 = '0; brk4 = '0; ine4 = '0; mem_valid4 = '0;
        mem_write4 = '0; excp4 = '0; mmu_resp4 = '0; vpc4 = '0; vlsu4 = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        redirect_ready = 1'b1;
        while (busy_o && n < 50) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    initial begin
        clear();
        redirect_ready = 1'b1;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ecode", 32'(ecode_o), 32'd0);

        // Pipe1 ALE, pipe0 clean.
        valid = 2'b11; excp[1].ale = 1'b1; vlsu[1] = 32'h0000_1003;
        #1 chk("ale_kill", 32'(kill_o), 32'b10);
        tick();
        clear();
        chk("ale_valid", 32'(excp_valid_o), 32'd1);
        chk("ale_ecode", 32'(ecode_o), 32'h09);
        chk("ale_badva", bad_va_o, 32'h0000_1003);
        chk("ale_era", era_o, 32'h0000_0104);
        wait_idle();

        // Pipe0 syscall beats pipe1 ADEF.
        valid = 2'b11; syscall[0] = 1'b1; excp[1].adef = 1'b1;
        #1 chk("sys_kill", 32'(kill_o), 32'b11);
        tick();
        clear();
        chk("sys_ecode", 32'(ecode_o), 32'h0b);
        chk("sys_era", era_o, 32'h0000_0100);
        chk("sys_vaerr", 32'(va_error_o), 32'd0);
        wait_idle();

        // Interrupt beats ITLBR on pipe0.
        valid = 2'b01; int_pending = 1'b1; excp[0].itlbr = 1'b1;
        tick();
        clear();
        chk("int_ecode", 32'(ecode_o), 32'h00);
        chk("int_tlbr", 32'(tlbrefill_o), 32'd0);
        chk("int_valid", 32'(excp_valid_o), 32'd1);
        wait_idle();

        // Interrupt ignored when pipe0 is empty.
        valid = 2'b10; int_pending = 1'b1;
        tick();
        clear();
        chk("int_nov_busy", 32'(busy_o), 32'd0);

        // DTLBR on pipe0 sets TLBR entry and BADV from the data address.
        valid = 2'b01; excp[0].dtlbr = 1'b1; vlsu[0] = 32'hdead_beef;
        tick();
        clear();
        chk("dtlbr_ecode", 32'(ecode_o), 32'h3f);
        chk("dtlbr_tlbr", 32'(tlbrefill_o), 32'd1);
        chk("dtlbr_badva", bad_va_o, 32'hdead_beef);
        wait_idle();

        // DPPI then PIL (load, invalid entry); translation off yields nothing.
        valid = 2'b01; trans_en = 1'b1; mem_valid[0] = 1'b1; plv = 2'd3;
        mmu_resp[0].v = 1'b1; mmu_resp[0].d = 1'b1; vlsu[0] = 32'h0000_2000;
        tick();
        clear();
        chk("dppi_ecode", 32'(ecode_o), 32'h07);
        wait_idle();
        valid = 2'b10; trans_en = 1'b1; mem_valid[1] = 1'b1; vlsu[1] = 32'h0000_3000;
        tick();
        clear();
        chk("pil_ecode", 32'(ecode_o), 32'h01);
        chk("pil_badva", bad_va_o, 32'h0000_3000);
        wait_idle();
        valid = 2'b01; mem_valid[0] = 1'b1; mem_write[0] = 1'b1;
        tick();
        clear();
        chk("notrans_busy", 32'(busy_o), 32'd0);

        // Redirect stall of 5 cycles, then a 2-cycle drain that ignores new faults.
        valid = 2'b01; ine[0] = 1'b1; redirect_ready = 1'b0;
        tick();
        clear();
        for (int i = 0; i < 5; i++) begin
            chk("stall_redirect", 32'(redirect_valid_o), 32'd1);
            tick();
        end
        redirect_ready = 1'b1;
        tick();
        chk("drain1_busy", 32'(busy_o), 32'd1);
        chk("drain1_redirect", 32'(redirect_valid_o), 32'd0);
        valid = 2'b01; excp[0].adef = 1'b1;
        #1 chk("drain_kill", 32'(kill_o), 32'b11);
        tick();
        clear();
        chk("drain2_busy", 32'(busy_o), 32'd1);
        chk("drain_no_pulse", 32'(excp_valid_o), 32'd0);
        tick();
        chk("drain_done", 32'(busy_o), 32'd0);

        // Reset during REDIRECT dominates a live fault and handshake.
        valid = 2'b01; excp[0].pif = 1'b1; redirect_ready = 1'b0;
        tick();
        rst = 1'b1; redirect_ready = 1'b1;
        tick();
        rst = 1'b0;
        clear();
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_redirect", 32'(redirect_valid_o), 32'd0);
        chk("rst_mid_valid", 32'(excp_valid_o), 32'd0);
        chk("rst_mid_era", era_o, 32'd0);
        chk("rst_mid_badva", bad_va_o, 32'd0);
        chk("rst_mid_vaerr", 32'(va_error_o), 32'd0);

        // Four pipes: pipe2 PME beats pipe3 PIS.
        trans_en = 1'b1; valid4 = 4'b1100;
        mem_valid4[2] = 1'b1; mem_write4[2] = 1'b1; mmu_resp4[2].v = 1'b1;
        vlsu4[2] = 32'h0000_4444; vpc4[2] = 32'h0000_0208;
        mem_valid4[3] = 1'b1; mem_write4[3] = 1'b1; vlsu4[3] = 32'h0000_5555;
        #1 chk("p4_kill", 32'(kill4), 32'b1100);
        tick();
        clear();
        chk("p4_ecode", 32'(ecode4), 32'h04);
        chk("p4_badva", bad_va4, 32'h0000_4444);
        chk("p4_era", era4, 32'h0000_0208);
        tick();
        tick();
        tick();
        tick();
        chk("p4_idle", 32'(busy4), 32'd0);

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
